pipeline_mdu: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).

---
 rtl/pipeline_mdu_pkg.sv | 29 ++
 rtl/pipeline_mdu_div_step.sv | 44 ++++
 rtl/pipeline_mdu.sv | 218 +++++++++++++++++++++
 tb/tb_pipeline_mdu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mdu_pkg.sv
// pipeline_defs: shared definitions for the MIPS multiply/divide unit.
//   mduOp_e    : iOp encodings (MULT, MULTU, DIV, DIVU)
//   mduState_e : iteration FSM states (IDLE, CALC, FIX)
//   mduIsDiv / mduIsSigned : decode helpers for a raw 2-bit op field
package pipeline_defs;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mduOp_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mduState_e;

    // Bit 1 of the op selects divide, bit 0 selects the unsigned variant.
    function automatic logic mduIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic mduIsSigned(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/pipeline_mdu_div_step.sv
// mdu_div_step: combinational restoring-division slice, RADIX_BITS iterations.
//   iRem     : partial remainder (always < iDivisor when iDivisor != 0)
//   iQuo     : dividend bits still to be shifted in (MSB first); quotient
//              bits are shifted in at the bottom as they are produced
//   iDivisor : divisor magnitude
//   oRem     : partial remainder after RADIX_BITS iterations
//   oQuo     : shifted dividend/quotient register after RADIX_BITS iterations
module mdu_div_step
    import pipeline_defs::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic [XLEN-1:0] iRem,
    input  logic [XLEN-1:0] iQuo,
    input  logic [XLEN-1:0] iDivisor,
    output logic [XLEN-1:0] oRem,
    output logic [XLEN-1:0] oQuo
);

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;

    always_comb begin
        rem   = iRem;
        quo   = iQuo;
        trial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            // Bring down the next dividend bit; one extra bit of headroom
            // because rem < divisor implies 2*rem+1 < 2*divisor.
            trial = {rem, quo[XLEN-1]};
            quo   = {quo[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, iDivisor}) begin
                trial  = trial - {1'b0, iDivisor};
                quo[0] = 1'b1;
            end
            rem = trial[XLEN-1:0];
        end
        oRem = rem;
        oQuo = quo;
    end

endmodule

// File: rtl/pipeline_mdu.sv
// pipeline_mdu: iterative multiply/divide unit with HI/LO for a 5-stage MIPS core.
// Optional feature macro: PIPELINE_MDU_FAST_MULT_EN (single-cycle multiply;
// divide stays iterative). Undefined by default.
//
// Handshake: the core raises iStart for one op while oBusy=0; the op is taken
// at that edge unless iCancel is also high. While oBusy=1 iStart/iWriteHI/
// iWriteLO are ignored. oDone pulses one cycle once HI/LO hold the result.
//
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   iStart, iOp, iA, iB : op request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   iCancel             : abort in-flight op, HI/LO untouched
//   iWriteHI, iWriteLO  : MTHI/MTLO from iA, idle only, dropped if iStart
//   oBusy, oDone        : op in flight / result-written pulse
//   oHI, oLO            : architectural HI/LO
//   dbgState            : current FSM state
module pipeline_mdu
    import pipeline_defs::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iStart,
    input  logic [1:0]      iOp,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    input  logic            iCancel,
    input  logic            iWriteHI,
    input  logic            iWriteLO,
    output logic            oBusy,
    output logic            oDone,
    output logic [XLEN-1:0] oHI,
    output logic [XLEN-1:0] oLO,
    output mduState_e       dbgState
);

    localparam int N     = XLEN / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    mduState_e         state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic              isDivReg;
    logic [XLEN-1:0]   accHi, accLo;     // product hi/lo or remainder/quotient
    logic [XLEN-1:0]   opnd;             // multiplicand or divisor magnitude
    logic              negQ, negR;       // sign fix for product/quotient, remainder
    logic              divZero;
    logic [XLEN-1:0]   dividendRaw;      // returned in HI on divide by zero
    logic [XLEN-1:0]   hiReg, loReg;
    logic              doneReg;

    // ------------------------------------------------------------ accept
    logic            accept, startIter;
    logic            signA, signB;
    logic [XLEN-1:0] magA, magB;

    assign accept = (state == MDU_IDLE) && iStart && !iCancel;
    assign signA  = mduIsSigned(iOp) & iA[XLEN-1];
    assign signB  = mduIsSigned(iOp) & iB[XLEN-1];
    // -x of the most negative value is 2^(XLEN-1), correct as a magnitude.
    assign magA   = signA ? -iA : iA;
    assign magB   = signB ? -iB : iB;

`ifdef PIPELINE_MDU_FAST_MULT_EN
    logic                     startFast;
    logic signed [XLEN:0]     fastA, fastB;
    logic signed [2*XLEN+1:0] fastProd;

    assign startFast = accept && !mduIsDiv(iOp);
    assign startIter = accept && mduIsDiv(iOp);
    // One extra bit lets the same signed multiplier serve MULT and MULTU.
    assign fastA     = {signA, iA};
    assign fastB     = {signB, iB};
    assign fastProd  = fastA * fastB;
`else
    assign startIter = accept;
`endif

    // ------------------------------------------------------------ step logic
    // Shift-add multiply: add opnd * accLo[RADIX_BITS-1:0] into accHi, then
    // shift {accHi,accLo} right by RADIX_BITS. Built from shifted adds.
    logic [XLEN+RADIX_BITS-1:0] mulSum;
    logic [XLEN-1:0]            mulHiNext, mulLoNext;

    always_comb begin
        mulSum = {{RADIX_BITS{1'b0}}, accHi};
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (accLo[j]) begin
                mulSum = mulSum + ({{RADIX_BITS{1'b0}}, opnd} << j);
            end
        end
    end

    assign mulHiNext = mulSum[XLEN+RADIX_BITS-1:RADIX_BITS];
    assign mulLoNext = {mulSum[RADIX_BITS-1:0], accLo[XLEN-1:RADIX_BITS]};

    logic [XLEN-1:0] divRem, divQuo;

    mdu_div_step #(
        .XLEN       (XLEN),
        .RADIX_BITS (RADIX_BITS)
    ) uDivStep (
        .iRem     (accHi),
        .iQuo     (accLo),
        .iDivisor (opnd),
        .oRem     (divRem),
        .oQuo     (divQuo)
    );

    // ------------------------------------------------------------ sign fix
    logic [2*XLEN-1:0] prodMag, prodRes;
    logic [XLEN-1:0]   quoRes, remRes;

    assign prodMag = {accHi, accLo};
    assign prodRes = negQ ? -prodMag : prodMag;
    assign quoRes  = negQ ? -accLo : accLo;
    assign remRes  = negR ? -accHi : accHi;

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MDU_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            MDU_IDLE: if (startIter) nextState = MDU_CALC;
            MDU_CALC: begin
                if (iCancel)          nextState = MDU_IDLE;
                else if (cnt == '0)   nextState = MDU_FIX;
            end
            MDU_FIX:  nextState = MDU_IDLE;
            default:  nextState = MDU_IDLE;
        endcase
    end

    always_comb begin
        oBusy    = (state != MDU_IDLE);
        dbgState = state;
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            isDivReg    <= 1'b0;
            accHi       <= '0;
            accLo       <= '0;
            opnd        <= '0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            divZero     <= 1'b0;
            dividendRaw <= '0;
            hiReg       <= '0;
            loReg       <= '0;
            doneReg     <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (startIter) begin
                isDivReg    <= mduIsDiv(iOp);
                cnt         <= CNT_W'(N - 1);
                accHi       <= '0;
                accLo       <= mduIsDiv(iOp) ? magA : magB;
                opnd        <= mduIsDiv(iOp) ? magB : magA;
                negQ        <= signA ^ signB;
                negR        <= signA;
                divZero     <= mduIsDiv(iOp) && (iB == '0);
                dividendRaw <= iA;
            end
`ifdef PIPELINE_MDU_FAST_MULT_EN
            else if (startFast) begin
                hiReg   <= fastProd[2*XLEN-1:XLEN];
                loReg   <= fastProd[XLEN-1:0];
                doneReg <= 1'b1;
            end
`endif
            else if (state == MDU_IDLE && !iStart) begin
                if (iWriteHI) hiReg <= iA;
                if (iWriteLO) loReg <= iA;
            end else if (state == MDU_CALC) begin
                if (iCancel) begin
                    cnt <= '0;
                end else begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    if (isDivReg) begin
                        accHi <= divRem;
                        accLo <= divQuo;
                    end else begin
                        accHi <= mulHiNext;
                        accLo <= mulLoNext;
                    end
                end
            end else if (state == MDU_FIX && !iCancel) begin
                doneReg <= 1'b1;
                if (!isDivReg) begin
                    hiReg <= prodRes[2*XLEN-1:XLEN];
                    loReg <= prodRes[XLEN-1:0];
                end else if (divZero) begin
                    hiReg <= dividendRaw;
                    loReg <= '1;
                end else begin
                    hiReg <= remRes;
                    loReg <= quoRes;
                end
            end
        end
    end

    assign oDone = doneReg;
    assign oHI   = hiReg;
    assign oLO   = loReg;

endmodule

// File: tb/tb_pipeline_mdu.sv
// Scoreboard bench for pipeline_mdu. Expected HI/LO come from plain 64-bit
// arithmetic on the operands; the monitor pops one expectation (value and
// oDone cycle) per oDone pulse.
module tb_pipeline_mdu;
    import pipeline_defs::*;

    localparam int XLEN     = 32;
    localparam int RB       = 1;
    localparam int N        = XLEN / RB;
    localparam int ITER_LAT = N + 1;
`ifdef PIPELINE_MDU_FAST_MULT_EN
    localparam int MUL_LAT  = 0;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = ITER_LAT;
    localparam int MUL_BUSY = N + 1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            iStart, iCancel, iWriteHI, iWriteLO;
    logic [1:0]      iOp;
    logic [XLEN-1:0] iA, iB;
    logic            oBusy, oDone;
    logic [XLEN-1:0] oHI, oLO;
    mduState_e       dbgState;

    pipeline_mdu #(.XLEN(XLEN), .RADIX_BITS(RB)) dut (
        .clk      (clk),
        .reset    (reset),
        .iStart   (iStart),
        .iOp      (iOp),
        .iA       (iA),
        .iB       (iB),
        .iCancel  (iCancel),
        .iWriteHI (iWriteHI),
        .iWriteLO (iWriteLO),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oHI      (oHI),
        .oLO      (oLO),
        .dbgState (dbgState)
    );

    // ---------------------------------------------------- clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------- scoreboard state
    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;
    int          done_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: MIPS HI/LO semantics via 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00:   return 64'(sa * sb);
            2'b01:   return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------------------------------------------- monitor
    task automatic monitor();
        logic [63:0] e;
        int          c;
        forever begin
            @(negedge clk);
            if (oDone === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {oHI, oLO}, 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    chk("result_hilo", {oHI, oLO}, e);
                    chk("done_cycle", 64'(cyc), 64'(c));
                end
            end
        end
    endtask

    // ---------------------------------------------------- driver tasks
    // Called just after a falling edge; returns one falling edge after the
    // accepting rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int          lat;
        r   = ref_model(op, a, b);
        lat = op[1] ? ITER_LAT : MUL_LAT;
        exp_q.push_back(r);
        exp_cyc_q.push_back(cyc + 1 + lat);
        mdl_hi = r[63:32];
        mdl_lo = r[31:0];
        iOp = op; iA = a; iB = b; iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (oBusy === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("busy_timeout", {63'd0, oBusy}, 64'd0);
    endtask

    task automatic write_hilo(input bit hi, input bit lo, input logic [31:0] v);
        iWriteHI = hi; iWriteLO = lo; iA = v;
        @(negedge clk);
        iWriteHI = 1'b0; iWriteLO = 1'b0;
        if (hi) mdl_hi = v;
        if (lo) mdl_lo = v;
        chk("mthi_value", {32'd0, oHI}, {32'd0, mdl_hi});
        chk("mtlo_value", {32'd0, oLO}, {32'd0, mdl_lo});
    endtask

    // ---------------------------------------------------- main sequence
    initial begin
        int busy_cnt;
        int s;
        int done_before;

        reset = 1'b0;
        iStart = 1'b0; iCancel = 1'b0; iWriteHI = 1'b0; iWriteLO = 1'b0;
        iOp = 2'b00; iA = '0; iB = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, oBusy}, 64'd0);
        chk("reset_done", {63'd0, oDone}, 64'd0);
        chk("reset_hilo", {oHI, oLO}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_state", {62'd0, dbgState}, {62'd0, MDU_IDLE});

        // MULTU all-ones: latency and busy window.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busy_cnt = 0;
        while (oBusy === 1'b1 && busy_cnt < 200) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk("multu_busy_cycles", 64'(busy_cnt), 64'(MUL_BUSY));

        issue(2'b00, -32'd3, 32'd7);            wait_idle();
        issue(2'b10, -32'd7, 32'd2);            wait_idle();
        issue(2'b11, 32'd100, 32'd0);           wait_idle();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(2'b10, 32'hFFFF_FFF9, 32'd0);     wait_idle();
        issue(2'b11, 32'd100, 32'd7);           wait_idle();
        issue(2'b01, 32'd6, 32'd7);             wait_idle();
        @(negedge clk);
        chk("hilo_hold", {oHI, oLO}, {mdl_hi, mdl_lo});

        // MTHI then cancelled DIVU: HI/LO untouched, no oDone.
        write_hilo(1'b1, 1'b0, 32'h0000_1234);
        done_before = done_seen;
        iOp = 2'b11; iA = 32'd10; iB = 32'd3; iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        s = cyc;
        while (cyc < s + 9) @(negedge clk);
        iCancel = 1'b1;
        @(negedge clk);
        iCancel = 1'b0;
        chk("cancel_busy_low", {63'd0, oBusy}, 64'd0);
        repeat (N + 4) @(negedge clk);
        chk("cancel_no_done", 64'(done_seen - done_before), 64'd0);
        chk("cancel_hilo", {oHI, oLO}, {32'h0000_1234, mdl_lo});

        // iStart together with iCancel in IDLE starts nothing.
        iOp = 2'b10; iA = 32'd50; iB = 32'd5; iStart = 1'b1; iCancel = 1'b1;
        @(negedge clk);
        iStart = 1'b0; iCancel = 1'b0;
        chk("start_cancel_idle", {63'd0, oBusy}, 64'd0);

        // iStart held and MTLO/MTHI pulsed during a divide: all ignored.
        issue(2'b10, 32'hFFFF_0000, 32'd9);
        iStart = 1'b1; iA = 32'd3; iB = 32'd1;
        repeat (N / 4) @(negedge clk);
        iWriteLO = 1'b1; iA = 32'hDEAD_BEEF;
        @(negedge clk);
        iWriteLO = 1'b0; iWriteHI = 1'b1;
        @(negedge clk);
        iWriteHI = 1'b0; iStart = 1'b0;
        wait_idle();
        // Back-to-back: next op issued in the oDone cycle.
        issue(2'b11, 32'd1000, 32'd33);
        wait_idle();
        @(negedge clk);
        chk("after_b2b_hilo", {oHI, oLO}, {mdl_hi, mdl_lo});

        // Randomised ops, mostly back-to-back, with occasional MTHI/MTLO.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
            issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
            wait_idle();
        end

        // Reset in the middle of an op.
        @(negedge clk);
        write_hilo(1'b1, 1'b1, 32'hA5A5_5A5A);
        iOp = 2'b11; iA = 32'd77; iB = 32'd5; iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midop_reset_busy", {63'd0, oBusy}, 64'd0);
        chk("midop_reset_hilo", {oHI, oLO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        mdl_hi = '0; mdl_lo = '0;
        @(negedge clk);
        issue(2'b10, 32'd100, -32'd7);
        wait_idle();

        repeat (N + 4) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
